// File: rtl/nco_clken_pkg.sv
// Shared helpers for the multi-channel NCO clock-enable generator: index and
// counter widths, and a constant function for deriving increments from frequencies.
package nco_clken_pkg;

    function automatic int ch_idx_w(input int channels);
        if (channels > 1) begin
            return $clog2(channels);
        end else begin
            return 1;
        end
    endfunction

    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

    // round(f_out * 2^acc_w / f_clk) by bit-serial long division; assumes f_out < f_clk
    function automatic logic [63:0] inc_from_hz(
        input longint unsigned f_clk,
        input longint unsigned f_out,
        input int              acc_w
    );
        logic [63:0] rem;
        logic [63:0] quo;
        rem = f_out % f_clk;
        quo = 64'd0;
        for (int b = 0; b < acc_w + 1; b++) begin
            rem = rem << 1;
            quo = quo << 1;
            if (rem >= f_clk) begin
                rem = rem - f_clk;
                quo = quo | 64'd1;
            end else begin
                quo = quo;
            end
        end
        return (quo + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/nco_clken_gen_ch.sv
// One NCO channel: increment register, phase accumulator, carry-out enable and
// MSB square wave, all taken straight from registers.
module nco_clken_ch
    import nco_clken_pkg::*;
#(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = {ACC_W{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_wr_en,
    input  logic [ACC_W-1:0] i_wr_inc,
    input  logic             i_sync,
    output logic             o_ce,
    output logic             o_sq
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    // Phase accumulation; sync realigns phase and suppresses the pending carry
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_acc <= {ACC_W{1'b0}};
            r_ce  <= 1'b0;
        end else if (i_sync) begin
            r_acc <= {ACC_W{1'b0}};
            r_ce  <= 1'b0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_sum[ACC_W];
        end
    end

    // Increment register; a write never touches the accumulator, so no phase jump
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_inc <= INC_RST;
        end else if (i_wr_en) begin
            r_inc <= i_wr_inc;
        end else begin
            r_inc <= r_inc;
        end
    end

    assign o_ce = r_ce;
    assign o_sq = r_acc[ACC_W-1];

endmodule

// File: rtl/nco_clken_gen.sv
// Multi-channel fractional clock-enable synthesiser: write decode, sync fan-out,
// lock-settle counter and the per-channel NCO instances.
module nco_clken_gen
    import nco_clken_pkg::*;
#(
    parameter int                          CHANNELS    = 2,
    parameter int                          ACC_W       = 32,
    parameter int                          LOCK_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_W-1:0]   INC_INIT    = {32'h0F5C28F6, 32'h9999999A}
) (
    input  logic                            clkin,
    input  logic                            rstn,
    input  logic                            wr_en,
    input  logic [ch_idx_w(CHANNELS)-1:0]   wr_ch,
    input  logic [ACC_W-1:0]                wr_inc,
    input  logic                            sync,
    output logic [CHANNELS-1:0]             ce,
    output logic [CHANNELS-1:0]             sq,
    output logic                            locked
);

    localparam int               CNT_W    = lock_cnt_w(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic                w_wr_valid;
    logic [CHANNELS-1:0] w_ch_wr;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_locked;

    // Out-of-range channel writes are dropped entirely, including their effect on lock
    assign w_wr_valid = wr_en && (int'(wr_ch) < CHANNELS);

    // One-hot write enable per channel
    always_comb begin
        w_ch_wr = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr_valid && (int'(wr_ch) == c)) begin
                w_ch_wr[c] = 1'b1;
            end else begin
                w_ch_wr[c] = 1'b0;
            end
        end
    end

    // Settle counter: restarts on any reconfiguration, saturates at the lock point
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr_valid || sync) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (r_cnt != LOCK_MAX) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Lock state; locked tracks the updated count so it rises on the LOCK_CYCLES-th quiet edge
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_locked <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_locked <= (w_cnt_next == LOCK_MAX);
        end
    end

    assign locked = r_locked;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        nco_clken_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[g*ACC_W +: ACC_W])
        ) u_ch (
            .i_clk    (clkin),
            .i_rstn   (rstn),
            .i_wr_en  (w_ch_wr[g]),
            .i_wr_inc (wr_inc),
            .i_sync   (sync),
            .o_ce     (ce[g]),
            .o_sq     (sq[g])
        );
    end

endmodule
